serial_out_port: RTL and testbench
==================================

Name: serial_out_port

Overview:
- Memory-mapped output peripheral that sits on the CPU data bus as a responder to the CPU's data-memory store and load cycles.
- Byte writes from the CPU go into a small FIFO. A transmit engine drains the FIFO onto a single serial line: one start bit, 8 data bits LSB-first, one stop bit.
- The CPU polls a status register so software can avoid overflowing the FIFO.
- The port occupies a two-address window in the data address space, addressed by the X register, alongside data RAM.

Parameters:
- BASE, 8'hF0, window base address. DATA register at BASE, STATUS register at BASE+1.
- DEPTH, 4, FIFO entries; power of two, 2..16.
- CLKS_PER_BIT, 16, clock cycles per serial bit; at least 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- sel  input  1  data-memory cycle select (memory assert, non-immediate).
- store  input  1  1 = write cycle, 0 = read cycle; meaningful only while sel=1.
- addr  input  8  data address (X register).
- dbus  inout  8  shared data bus; driven only during a read of the window, otherwise 'z.
- txd  output  1  serial line; idle high.
- busy  output  1  1 while FIFO non-empty or a frame is in flight.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty, overflow flag cleared.
  - FSM in IDLE, bit counter and baud counter zero.
  - txd=1, busy=0, dbus not driven.
- Hit: hit = sel && (addr==BASE || addr==BASE+1). Addresses outside the window are ignored entirely: no drive, no state change.
- Read (hit && !store): dbus is driven combinationally while the condition holds.
  - DATA reads 8'h00.
  - STATUS reads {4'b0, overflow, empty, full, busy} (bit0=busy, bit1=full, bit2=empty, bit3=overflow).
  - Reads have no side effects.
- Write (hit && store) takes effect at the rising clk edge.
  - DATA: push dbus into the FIFO. If full, the byte is dropped and overflow is set (sticky).
  - STATUS: clears overflow, whatever the data value.
- FIFO:
  - Circular buffer, DEPTH entries. Pointers are one bit wider than needed so full and empty are distinguished; they wrap modulo 2*DEPTH.
  - Push and pop in the same cycle are both honoured and the count is unchanged. A push into a full FIFO that coincides with a pop succeeds, and overflow is not set.
- Transmit FSM, states IDLE, START, DATA, STOP:
  - IDLE: txd=1. If the FIFO is non-empty at an edge: pop the head into shift register, baud counter=0, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After bit index 7, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START with no idle gap; else go to IDLE.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
- Latency: a DATA write at edge N with FSM idle and FIFO empty gives a pop at edge N+1, and txd falls just after edge N+1.
- busy = (state != IDLE) || !empty. busy is registered-path only; it has no combinational dependence on bus inputs.
- txd is driven directly from a flop (glitch-free).
- A reset assertion mid-frame aborts immediately: txd=1, FIFO contents discarded.

Decomposition:
- Shared package:
  - register offsets (DATA_OFF=0, STATUS_OFF=1);
  - STATUS bit positions;
  - FSM state enum (2 bits).
- One sub-module: sync_fifo (parameter WIDTH=8, DEPTH), ports clk, reset, push, pop, din, dout, full, empty.
- Bus decode, status mux and the transmit FSM live in serial_out_port.

Test Plan:
1. Reset with CLKS_PER_BIT=4 -> txd=1, busy=0; STATUS read (sel=1, store=0, addr=F1) gives dbus=8'h04.
2. Write 8'hA5 to F0 -> txd sequence over 40 cycles is 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. busy=1 throughout, 0 after the stop bit. STATUS reads 8'h04 afterwards.
3. Write 8'h01, 8'h02 on consecutive cycles -> two frames back-to-back, 80 cycles total, no idle cycle between the first stop bit and the second start bit.
4. With FSM busy, write 6 bytes 8'h10..8'h15 (DEPTH=4) -> STATUS shows full=1 and overflow=1 (8'h0B). Only the bytes that fit are transmitted, in order. A write to F1 then gives overflow=0.
5. Read/write at addr=F2, F0 with sel=0, and addr=EF -> dbus stays 'z, no FIFO change, txd remains 1.
6. Assert reset during data bit 3 of a frame with 2 bytes queued -> txd=1 immediately; after release, busy=0, STATUS=8'h04, and no further frames are sent.

Source files
------------

// File: rtl/serial_out_port_pkg.sv
// Shared definitions for the serial output port: register map, STATUS bit
// positions and the transmit FSM state encoding.
package serial_out_port_pkg;

    // Register offsets from BASE within the two-address window
    localparam logic [7:0] DATA_OFF   = 8'd0;
    localparam logic [7:0] STATUS_OFF = 8'd1;

    // STATUS register bit positions
    localparam int unsigned ST_BUSY  = 0;
    localparam int unsigned ST_FULL  = 1;
    localparam int unsigned ST_EMPTY = 2;
    localparam int unsigned ST_OVF   = 3;

    // Transmit FSM states
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO. Pointers carry one extra wrap bit so that the
// full and empty conditions are distinguishable. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_q[AW-1:0]];

    // Next-state pointer arithmetic; wraps naturally modulo 2*DEPTH
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + (AW+1)'(1);
        if (do_pop)  rd_d = rd_q + (AW+1)'(1);
    end

    // Pointer registers, cleared by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/serial_out_port.sv
// Memory-mapped serial output port. CPU stores to DATA queue bytes in a FIFO;
// a transmit FSM sends each as start bit, 8 data bits LSB-first, stop bit.
// STATUS exposes busy/full/empty/overflow; a STATUS store clears overflow.
module serial_out_port
    import serial_out_port_pkg::*;
#(
    parameter logic [7:0]  BASE         = 8'hF0,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sel,
    input  logic       store,
    input  logic [7:0] addr,
    inout  logic [7:0] dbus,
    output logic       txd,
    output logic       busy
);

    localparam int unsigned BW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [7:0] DATA_ADDR    = BASE + DATA_OFF;
    localparam logic [7:0] STATUS_ADDR  = BASE + STATUS_OFF;

    tx_state_e     state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          ovf_q, ovf_d;

    logic          hit_data, hit_status;
    logic          wr_data, wr_status, rd_hit;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [7:0]    status;
    logic [7:0]    rd_data;
    logic          bit_end;

    assign hit_data   = sel && (addr == DATA_ADDR);
    assign hit_status = sel && (addr == STATUS_ADDR);
    assign wr_data    = hit_data && store;
    assign wr_status  = hit_status && store;
    assign rd_hit     = (hit_data || hit_status) && !store;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_data),
        .pop   (fifo_pop),
        .din   (dbus),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign busy = (state_q != TX_IDLE) || !fifo_empty;
    assign txd  = txd_q;

    // STATUS assembly and read-data mux; bus is released outside window reads
    always_comb begin
        status           = '0;
        status[ST_BUSY]  = busy;
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = fifo_empty;
        status[ST_OVF]   = ovf_q;
        rd_data          = hit_status ? status : 8'h00;
    end

    assign dbus = rd_hit ? rd_data : 'z;

    // Sticky overflow: set by a dropped DATA store, cleared by any STATUS store
    always_comb begin
        ovf_d = ovf_q;
        if (wr_status)
            ovf_d = 1'b0;
        else if (wr_data && fifo_full && !fifo_pop)
            ovf_d = 1'b1;
    end

    assign bit_end = (baud_q == BAUD_LAST);

    // Transmit FSM next state; txd_d is the level for the cycle after the edge,
    // so the line comes straight from a flop
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            TX_IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    baud_d   = '0;
                    state_d  = TX_START;
                    txd_d    = 1'b0;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = TX_DATA;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = TX_START;
                        txd_d    = 1'b0;
                    end else begin
                        state_d = TX_IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = TX_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    // FSM, counters, shift register, line and overflow registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_serial_out_port.sv
// Directed bench for serial_out_port with CLKS_PER_BIT=4, DEPTH=4.
module tb_serial_out_port;

    logic       clk = 1'b0;
    logic       reset;
    logic       sel;
    logic       store;
    logic [7:0] addr;
    wire  [7:0] dbus;
    logic       txd;
    logic       busy;
    logic       tb_drv;
    logic [7:0] tb_val;

    int n_checks = 0;
    int n_fail   = 0;

    assign dbus = tb_drv ? tb_val : 8'hzz;

    always #5 clk = ~clk;

    serial_out_port #(
        .BASE         (8'hF0),
        .DEPTH        (4),
        .CLKS_PER_BIT (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .store (store),
        .addr  (addr),
        .dbus  (dbus),
        .txd   (txd),
        .busy  (busy)
    );

    typedef struct {
        logic       sel;
        logic       store;
        logic [7:0] addr;
        logic       drv;
        logic [7:0] val;
        logic [7:0] exp_bus;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge
    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        sel    = 1'b1;
        store  = 1'b1;
        addr   = a;
        tb_drv = 1'b1;
        tb_val = d;
        @(negedge clk);
        sel    = 1'b0;
        store  = 1'b0;
        tb_drv = 1'b0;
        addr   = 8'h00;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        sel    = 1'b1;
        store  = 1'b0;
        addr   = a;
        tb_drv = 1'b0;
        #1;
        d      = dbus;
        sel    = 1'b0;
        addr   = 8'h00;
    endtask

    // Checks every cycle of a frame starting with the current cycle as start-bit cycle 0
    task automatic check_frame(input logic [7:0] b, input string name);
        logic [9:0] lv;
        lv = {1'b1, b, 1'b0};
        for (int i = 0; i < 40; i++) begin
            check($sformatf("%s txd cyc%0d", name, i), {7'b0, txd}, {7'b0, lv[i/4]});
            check($sformatf("%s busy cyc%0d", name, i), {7'b0, busy}, 8'h01);
            @(negedge clk);
        end
    endtask

    // Bounded wait for a start bit, then mid-bit sampling; leaves the bench at
    // the cycle after the stop bit
    task automatic rx_byte(output logic [7:0] b, output logic ok);
        int t;
        t  = 0;
        ok = 1'b1;
        b  = 8'h00;
        while (txd !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            ok = 1'b0;
        end else begin
            repeat (2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                repeat (4) @(negedge clk);
                b[k] = txd;
            end
            repeat (4) @(negedge clk);
            check("rx stop bit", {7'b0, txd}, 8'h01);
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic [7:0] rxb;
        logic       ok;
        logic       stayed_high;

        vecs[0] = '{1'b1, 1'b0, 8'hF2, 1'b1, 8'hA0, 8'hA0};
        vecs[1] = '{1'b1, 1'b1, 8'hF2, 1'b1, 8'h33, 8'h33};
        vecs[2] = '{1'b0, 1'b0, 8'hF0, 1'b1, 8'hA0, 8'hA0};
        vecs[3] = '{1'b0, 1'b1, 8'hF0, 1'b1, 8'h44, 8'h44};
        vecs[4] = '{1'b0, 1'b0, 8'hF1, 1'b1, 8'hA0, 8'hA0};
        vecs[5] = '{1'b1, 1'b0, 8'hEF, 1'b1, 8'hA0, 8'hA0};
        vecs[6] = '{1'b1, 1'b1, 8'hEF, 1'b1, 8'h55, 8'h55};
        vecs[7] = '{1'b1, 1'b0, 8'hF1, 1'b0, 8'h00, 8'h04};
        vecs[8] = '{1'b1, 1'b0, 8'hF0, 1'b0, 8'h00, 8'h00};

        reset  = 1'b0;
        sel    = 1'b0;
        store  = 1'b0;
        addr   = 8'h00;
        tb_drv = 1'b0;
        tb_val = 8'h00;

        // 1. Reset state
        repeat (3) @(negedge clk);
        check("reset txd", {7'b0, txd}, 8'h01);
        check("reset busy", {7'b0, busy}, 8'h00);
        reset = 1'b1;
        @(negedge clk);
        check("post-reset txd", {7'b0, txd}, 8'h01);
        check("post-reset busy", {7'b0, busy}, 8'h00);
        bus_read(8'hF1, rd);
        check("reset status", rd, 8'h04);
        @(negedge clk);

        // 5. Decode table: misses must not drive the bus or change state
        for (int v = 0; v < 9; v++) begin
            sel    = vecs[v].sel;
            store  = vecs[v].store;
            addr   = vecs[v].addr;
            tb_drv = vecs[v].drv;
            tb_val = vecs[v].val;
            #1;
            check($sformatf("vec%0d dbus", v), dbus, vecs[v].exp_bus);
            @(negedge clk);
            sel    = 1'b0;
            store  = 1'b0;
            tb_drv = 1'b0;
            addr   = 8'h00;
            check($sformatf("vec%0d busy", v), {7'b0, busy}, 8'h00);
            check($sformatf("vec%0d txd", v), {7'b0, txd}, 8'h01);
        end
        bus_read(8'hF1, rd);
        check("decode status after", rd, 8'h04);
        @(negedge clk);

        // 2. Single frame of A5
        bus_write(8'hF0, 8'hA5);
        check("A5 busy at write", {7'b0, busy}, 8'h01);
        check("A5 txd before pop", {7'b0, txd}, 8'h01);
        @(negedge clk);
        check_frame(8'hA5, "A5");
        check("A5 busy after", {7'b0, busy}, 8'h00);
        check("A5 txd after", {7'b0, txd}, 8'h01);
        bus_read(8'hF1, rd);
        check("A5 status after", rd, 8'h04);
        @(negedge clk);

        // 3. Back-to-back frames with no idle gap
        bus_write(8'hF0, 8'h01);
        bus_write(8'hF0, 8'h02);
        check_frame(8'h01, "b2b01");
        check_frame(8'h02, "b2b02");
        check("b2b busy after", {7'b0, busy}, 8'h00);
        check("b2b txd after", {7'b0, txd}, 8'h01);
        @(negedge clk);

        // 4. Overflow while transmitting
        bus_write(8'hF0, 8'hFF);
        @(negedge clk);
        for (int i = 0; i < 6; i++) bus_write(8'hF0, 8'h10 + 8'(i));
        bus_read(8'hF1, rd);
        check("ovf status", rd, 8'h0B);
        @(negedge clk);
        bus_write(8'hF1, 8'h00);
        bus_read(8'hF1, rd);
        check("ovf cleared status", rd, 8'h03);
        for (int i = 0; i < 4; i++) begin
            rx_byte(rxb, ok);
            check($sformatf("ovf rx%0d timeout", i), {7'b0, ok}, 8'h01);
            check($sformatf("ovf rx%0d data", i), rxb, 8'h10 + 8'(i));
        end
        check("ovf busy after", {7'b0, busy}, 8'h00);
        stayed_high = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (txd !== 1'b1) stayed_high = 1'b0;
        end
        check("ovf no extra frame", {7'b0, stayed_high}, 8'h01);
        bus_read(8'hF1, rd);
        check("ovf final status", rd, 8'h04);
        @(negedge clk);

        // 6. Reset during data bit 3 with two bytes queued
        bus_write(8'hF0, 8'h55);
        bus_write(8'hF0, 8'hAA);
        bus_write(8'hF0, 8'hCC);
        repeat (16) @(negedge clk);
        check("pre-reset bit3 txd", {7'b0, txd}, 8'h00);
        bus_read(8'hF1, rd);
        check("pre-reset status", rd, 8'h01);
        #2;
        reset = 1'b0;
        #1;
        check("mid-reset txd", {7'b0, txd}, 8'h01);
        check("mid-reset busy", {7'b0, busy}, 8'h00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("after reset busy", {7'b0, busy}, 8'h00);
        bus_read(8'hF1, rd);
        check("after reset status", rd, 8'h04);
        stayed_high = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) stayed_high = 1'b0;
        end
        check("after reset idle line", {7'b0, stayed_high}, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
